// File: rtl/ai_led_stat_mon.sv
// rtl/ai_led_stat_mon.sv - front-panel LED status decoder with addressed code readback
//
// Watches 2*NUM_LED LED drive lines and classifies every line as OFF, ON,
// BLINK or UNSTABLE over a 2^WIN_BIT cycle window.
// LED k owns drive bits [2k+1:2k]. Its readback nibble is {code(bit 2k+1), code(bit 2k)}.
// Codes: 2'b00 OFF, 2'b01 ON, 2'b10 BLINK, 2'b11 UNSTABLE.
//
// Optional build macro: AI_LED_CHG_IRQ_EN.
//   When defined, a sticky per-LED change flag and a change interrupt are built.
//   When undefined, chg_irq is tied low.
//
// Ports:
//   clk_sys    in   system clock
//   rst_sys_n  in   asynchronous active-low reset
//   led_in     in   LED drive lines, 2*NUM_LED bits
//   win_done   out  one-cycle pulse when freshly latched codes become visible
//   rd_en      in   single-cycle read strobe
//   rd_addr    in   LED index to read
//   rd_vld     out  read data valid, one cycle after rd_en
//   rd_data    out  {code bit1, code bit0}; 0 for rd_addr >= NUM_LED
//   chg_irq    out  OR of sticky change flags, registered
module ai_led_stat_mon #(
  parameter int NUM_LED   = 15,
  parameter int WIN_BIT   = 27,
  parameter int BLINK_MIN = 1,
  parameter int BLINK_MAX = 12
) (
  input  logic                 clk_sys,
  input  logic                 rst_sys_n,
  input  logic [2*NUM_LED-1:0] led_in,
  output logic                 win_done,
  input  logic                 rd_en,
  input  logic [3:0]           rd_addr,
  output logic                 rd_vld,
  output logic [3:0]           rd_data,
  output logic                 chg_irq
);

  localparam int NB = 2 * NUM_LED;
  localparam logic [3:0] BMIN = 4'(BLINK_MIN);
  localparam logic [3:0] BMAX = 4'(BLINK_MAX);

  logic [NB-1:0]      led_q;
  logic               started;   // low only on the first cycle after reset
  logic [WIN_BIT-1:0] win_cnt;
  logic [3:0]         tcnt     [NB];
  logic [3:0]         tcnt_nxt [NB];
  logic [NB-1:0]      tgl;
  logic [2*NB-1:0]    codes;
  logic [2*NB-1:0]    codes_nxt;
  logic               win_end;
  logic [3:0]         rd_mux;

  function automatic logic [1:0] classify(input logic [3:0] cnt, input logic lvl);
    if (cnt > BMAX)       return 2'b11;
    else if (cnt >= BMIN) return 2'b10;
    else                  return {1'b0, lvl};
  endfunction

  assign win_end = &win_cnt;
  // led_q is loaded straight from led_in on the first cycle, so there is no
  // meaningful previous sample to compare against yet.
  assign tgl = started ? (led_in ^ led_q) : '0;

  // Counter value including this cycle's toggle, and the code it would latch.
  always_comb begin
    codes_nxt = '0;
    for (int j = 0; j < NB; j++) begin
      tcnt_nxt[j] = (tgl[j] && (tcnt[j] != 4'hF)) ? tcnt[j] + 4'd1 : tcnt[j];
      codes_nxt[2*j +: 2] = classify(tcnt_nxt[j], led_q[j]);
    end
  end

  always_comb begin
    rd_mux = 4'h0;
    for (int k = 0; k < NUM_LED; k++) begin
      if (rd_addr == 4'(k)) rd_mux = codes[4*k +: 4];
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      led_q    <= '0;
      started  <= 1'b0;
      win_cnt  <= '0;
      codes    <= '0;
      win_done <= 1'b0;
      rd_vld   <= 1'b0;
      rd_data  <= 4'h0;
      for (int j = 0; j < NB; j++) tcnt[j] <= 4'h0;
    end else begin
      led_q    <= led_in;
      started  <= 1'b1;
      win_cnt  <= win_cnt + WIN_BIT'(1);
      win_done <= win_end;
      // The closing window keeps a window-end toggle; the next one starts at 0.
      for (int j = 0; j < NB; j++) tcnt[j] <= win_end ? 4'h0 : tcnt_nxt[j];
      if (win_end) codes <= codes_nxt;
      // Reads use the codes before any latch on the same edge.
      rd_vld  <= rd_en;
      rd_data <= rd_en ? rd_mux : 4'h0;
    end
  end

`ifdef AI_LED_CHG_IRQ_EN
  logic [NUM_LED-1:0] chg_flag;
  logic [NUM_LED-1:0] chg_set;
  logic [NUM_LED-1:0] chg_clr;

  always_comb begin
    for (int k = 0; k < NUM_LED; k++) begin
      chg_set[k] = win_end && (codes_nxt[4*k +: 4] != codes[4*k +: 4]);
      chg_clr[k] = rd_en && (rd_addr == 4'(k));
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      chg_flag <= '0;
      chg_irq  <= 1'b0;
    end else begin
      // A new change on the clearing edge must not be lost.
      chg_flag <= (chg_flag & ~chg_clr) | chg_set;
      chg_irq  <= |chg_flag;
    end
  end
`else
  assign chg_irq = 1'b0;
`endif

endmodule

// File: tb/tb_ai_led_stat_mon.sv
// tb/tb_ai_led_stat_mon.sv - directed self-checking bench for ai_led_stat_mon (WIN_BIT=8)
module tb_ai_led_stat_mon;

  localparam int NUM_LED = 15;
  localparam int WIN     = 256;
`ifdef AI_LED_CHG_IRQ_EN
  localparam logic IRQ = 1'b1;
`else
  localparam logic IRQ = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        rst_sys_n;
  logic [29:0] led_in;
  logic        win_done;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic        rd_vld;
  logic [3:0]  rd_data;
  logic        chg_irq;

  int n_chk = 0;
  int n_err = 0;
  int ci    = 0;   // position of the current cycle inside the window
  int per5  = 0;
  int per6  = 0;

  ai_led_stat_mon #(
    .NUM_LED  (NUM_LED),
    .WIN_BIT  (8),
    .BLINK_MIN(1),
    .BLINK_MAX(12)
  ) dut (
    .clk_sys  (clk_sys),
    .rst_sys_n(rst_sys_n),
    .led_in   (led_in),
    .win_done (win_done),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_vld   (rd_vld),
    .rd_data  (rd_data),
    .chg_irq  (chg_irq)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    if (per5 != 0 && (ci % per5) == 0) led_in[5] = ~led_in[5];
    if (per6 != 0 && (ci % per6) == 0) led_in[6] = ~led_in[6];
    @(posedge clk_sys);
    #1;
    ci = (ci + 1) % WIN;
  endtask

  task automatic do_read(input logic [3:0] a, input logic [3:0] e);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en = 1'b0;
    check($sformatf("rd_vld[%0d]", a), 32'(rd_vld), 32'd1);
    check($sformatf("rd_data[%0d]", a), 32'(rd_data), 32'(e));
  endtask

  // Advance to the first cycle of the next window and confirm the pulse.
  task automatic wait_win();
    tick();
    while (ci != 0) tick();
    check("win_done", 32'(win_done), 32'd1);
  endtask

  initial begin
    int n;
    rst_sys_n = 1'b0;
    led_in    = 30'h4;   // LED1 bit0 high from reset onward: must read ON, not BLINK
    rd_en     = 1'b0;
    rd_addr   = 4'h0;
    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_win_done", 32'(win_done), 32'd0);
    check("rst_rd_vld", 32'(rd_vld), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_chg_irq", 32'(chg_irq), 32'd0);
    rst_sys_n = 1'b1;

    n = 0;
    while (win_done !== 1'b1 && n < 600) begin
      tick();
      n++;
    end
    check("first_window_len", 32'(n), 32'd256);
    ci = 0;

    // Window 2: codes from window 1, LED1 ON, everything else OFF.
    do_read(4'd0, 4'h0);
    check("irq_after_first_latch", 32'(chg_irq), 32'(IRQ));
    for (int a = 1; a < 16; a++) do_read(4'(a), (a == 1) ? 4'h1 : 4'h0);
    tick();
    check("rd_vld_idle", 32'(rd_vld), 32'd0);
    check("irq_cleared_w2", 32'(chg_irq), 32'd0);

    // Window 3: LED0 bit0 rises, bit5 toggles every 32, bit6 every 8.
    wait_win();
    led_in[0] = 1'b1;
    per5 = 32;
    per6 = 8;
    tick();
    check("win_done_low", 32'(win_done), 32'd0);

    // Window 4: codes from window 3.
    wait_win();
    check("irq_lag", 32'(chg_irq), 32'd0);
    do_read(4'd0, 4'h2);
    check("irq_w4", 32'(chg_irq), 32'(IRQ));
    do_read(4'd2, 4'h8);
    do_read(4'd3, 4'h3);
    tick();
    check("rd_vld_idle_w4", 32'(rd_vld), 32'd0);
    check("irq_cleared_w4", 32'(chg_irq), 32'd0);
    while (ci != WIN - 1) tick();
    do_read(4'd0, 4'h2);   // issued on the window-end cycle: old code
    check("win_done_end_read", 32'(win_done), 32'd1);

    // Window 5: codes from window 4, LED0 now steady ON.
    do_read(4'd0, 4'h1);
    check("irq_set_wins_clear", 32'(chg_irq), 32'(IRQ));
    do_read(4'd2, 4'h8);
    do_read(4'd3, 4'h3);
    do_read(4'd15, 4'h0);
    do_read(4'd1, 4'h1);
    tick();
    check("irq_cleared_w5", 32'(chg_irq), 32'd0);

    // Window 6: LED4 goes OFF -> ON.
    wait_win();
    check("irq_quiet_w6", 32'(chg_irq), 32'd0);
    led_in[8] = 1'b1;

    // Window 7: LED4 latched as BLINK (one transition).
    wait_win();
    tick();
    tick();
    check("irq_led4", 32'(chg_irq), 32'(IRQ));
    do_read(4'd4, 4'h2);
    check("irq_on_rd_vld", 32'(chg_irq), 32'(IRQ));
    tick();
    check("irq_after_read", 32'(chg_irq), 32'd0);

    // Window 8: LED4 steady ON.
    wait_win();
    do_read(4'd4, 4'h1);
    check("irq_led4_on", 32'(chg_irq), 32'(IRQ));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ai_led_stat_mon.md
Name: ai_led_stat_mon

Overview:
- Front-panel LED status decoder for the AI board: watches the 2-bit LED drive lines (run, err, com, ch0..ch11) and classifies each colour bit as OFF, ON, BLINK or UNSTABLE over a fixed observation window.
- Latched codes are read back per LED through an addressed read port.
- The diagnostic path uses this readback to upload front-panel state to the controller and to self-check the LED logic.

Parameters:
- NUM_LED, 15, number of 2-bit LED groups monitored; index 0=run, 1=err, 2=com, 3..14=ch0..ch11.
- WIN_BIT, 27, observation window length = 2^WIN_BIT clk_sys cycles (1.34 s at 100 MHz).
- BLINK_MIN, 1, minimum toggles in a window classified as BLINK.
- BLINK_MAX, 12, maximum toggles in a window classified as BLINK; more toggles means UNSTABLE.

Ports:
- clk_sys  input  1  system clock.
- rst_sys_n  input  1  reset.
- led_in  input  2*NUM_LED  LED drive lines; bits [2k+1:2k] belong to LED k.
- win_done  output  1  one-cycle pulse when a window closes and codes are latched.
- rd_en  input  1  read strobe, single cycle.
- rd_addr  input  4  LED index to read.
- rd_vld  output  1  read data valid, one cycle.
- rd_data  output  4  {code of bit1, code of bit0} for LED rd_addr.
- chg_irq  output  1  change interrupt (see Optional Feature).

Interface (already decided):
- One clock, clk_sys.
- Reset rst_sys_n is asynchronous and active-low.

Behaviour:
- Reset values:
  - all outputs 0;
  - window counter 0;
  - toggle counters 0;
  - latched codes 2'b00 (OFF);
  - previous-sample register 0.
- Sampling:
  - led_in is registered once (led_q).
  - A toggle on bit j is led_in[j] != led_q[j].
  - The first cycle after reset does not count as a toggle, because led_q loads directly on that cycle.
- Toggle counters:
  - One 4-bit counter per bit (2*NUM_LED counters).
  - Increments on a toggle and saturates at 15; never wraps.
- Window counter:
  - WIN_BIT wide, free-running, wraps from all-ones to 0.
  - The window ends on the cycle the counter is all-ones.
- Window end, same edge for every bit j:
  - Code latched from the counter value including that cycle's toggle:
    - cnt==0 and led_q[j]==0 → 2'b00 OFF;
    - cnt==0 and led_q[j]==1 → 2'b01 ON;
    - BLINK_MIN<=cnt<=BLINK_MAX → 2'b10 BLINK;
    - cnt>BLINK_MAX → 2'b11 UNSTABLE;
    - 0<cnt<BLINK_MIN → OFF/ON from the current level.
  - Toggle counters clear to 0 on the following edge, so the next window starts at 0. A toggle on the window-end cycle is counted in the closing window only.
  - win_done pulses 1 cycle after the latch, when the new codes are visible.
- Read port:
  - rd_en with rd_addr<NUM_LED → rd_vld=1 and rd_data={code[2k+1],code[2k]} on the next cycle.
  - rd_addr>=NUM_LED → rd_vld=1, rd_data=4'h0.
  - Back-to-back reads are allowed, one per cycle.
  - A read in the same cycle as a latch returns the old codes.
- Reset mid-window discards partial counts. The first valid codes appear after one full window.

Optional Feature:
- Macro: AI_LED_CHG_IRQ_EN.
- With the macro defined:
  - A per-LED sticky change flag sets when any latched code of that LED differs from its previous latched value.
  - chg_irq = OR of all flags, registered.
  - A read of LED k clears flag k on the rd_vld cycle.
  - A set on the same cycle as a clear wins the set.
- Without the macro: no flags are built and chg_irq is tied 0.

Test Plan (WIN_BIT=8, BLINK_MIN=1, BLINK_MAX=12):
- Reset, hold led_in=0 for 2 windows, read addr 0..14 → every rd_data=4'h0; win_done pulses every 256 cycles.
- led_in[0]=1 steady, read addr 0 after the window → rd_data=4'h1 (bit0 ON, bit1 OFF).
- Toggle led_in[5] every 32 cycles (8 toggles/window), read addr 2 → rd_data=4'h8 (bit1 BLINK).
- Toggle led_in[6] every 8 cycles (32 toggles, counter saturated at 15), read addr 3 → rd_data=4'h3 (UNSTABLE).
- Read addr 15 → rd_vld=1, rd_data=0; assert rd_en on the window-end cycle → returns pre-latch code.
- AI_LED_CHG_IRQ_EN: change LED 4 from OFF to ON → chg_irq=1 after win_done; read addr 4 → chg_irq=0 the next cycle. Without the macro, chg_irq stays 0.
